cmp_2b: RTL and testbench
=========================

Name: cmp_2b

Overview:
Registered magnitude comparator for two unsigned operands, 2 bits wide by default, producing mutually exclusive lt/eq/gt flags. It is the leaf slice used to build wider comparators: the 4-bit comparator combines two slices as eq = eq_hi & eq_lo, lt = lt_hi | (eq_hi & lt_lo), gt = gt_hi | (eq_hi & gt_lo). Cascade inputs let slices chain without external glue. Outputs are registered with a valid strobe.

Parameters:
WIDTH, 2, operand width in bits (legal range 1..16).
SIGNED_CMP, 0, 1 = operands are two's complement; 0 = unsigned.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  operands and cascade inputs are sampled this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
casc_eq  input  1  cascade: more-significant slices are equal (tie high when unused).
casc_lt  input  1  cascade: more-significant slices give A<B (tie low when unused).
casc_gt  input  1  cascade: more-significant slices give A>B (tie low when unused).
out_valid  output  1  registered result valid.
eq  output  1  A == B (after cascade).
lt  output  1  A < B (after cascade).
gt  output  1  A > B (after cascade).

Behaviour:
- Reset (async, rst=1): out_valid=0, eq=1, lt=0, gt=0 immediately, held while rst is high.
- Local compare: leq = (a==b); llt = a<b and lgt = a>b, both unsigned when SIGNED_CMP=0 and two's complement when SIGNED_CMP=1. Signed compare applies only to a standalone or most-significant slice; lower cascaded slices use SIGNED_CMP=0.
- Cascade merge: eq_n = casc_eq & leq; lt_n = casc_lt | (casc_eq & llt); gt_n = casc_gt | (casc_eq & lgt).
- Illegal cascade input (not exactly one of casc_eq/lt/gt high): priority casc_lt > casc_gt > casc_eq. Outputs stay one-hot.
- Latency 1: on a rising clk with in_valid=1, eq/lt/gt <= eq_n/lt_n/gt_n and out_valid <= 1.
- With in_valid=0: out_valid <= 0; eq/lt/gt hold their last value.
- Invariant: exactly one of eq/lt/gt is high at all times, including reset.
- Back-to-back: a new operand pair every cycle gives a new result every cycle. No backpressure.
- rst asserted mid-stream discards any in-flight result. First valid result comes one clock after the first in_valid following rst deassertion.

Optional Feature:
Macro CMP_2B_STATS_EN. When defined, adds outputs cnt_lt, cnt_eq and cnt_gt, each 16 bits. Each counter increments on every registered result of its type (in_valid=1 cycles), saturates at 16'hFFFF, and clears to 0 on rst. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst with in_valid=1 and a=3, b=0 -> eq=1, lt=0, gt=0, out_valid=0 throughout. Release rst -> next clock out_valid=1, gt=1.
- Standalone compare, cascade tied (casc_eq=1): a=0,b=0 -> eq; a=3,b=0 -> gt; a=0,b=3 -> lt; a=1,b=2 -> lt. Each result appears one cycle after in_valid.
- Exhaustive WIDTH=2 unsigned: all 16 a,b pairs back-to-back -> each output matches a<b / a==b / a>b and is one-hot.
- Two-slice chain (4-bit): high slice a[3:2], b[3:2]; its eq/lt/gt feed the low slice's casc_* inputs. Pipeline the low-slice operands by one cycle. Pairs 0/0, 3/0, 0/3, 7/5 -> final (lt,eq,gt) = 010, 001, 100, 001.
- Cascade override: casc_gt=1, casc_eq=0, a=0, b=3 -> gt=1. Illegal cascade casc_lt=casc_gt=1 -> lt=1.
- SIGNED_CMP=1, WIDTH=2: a=2'b10 (-2), b=2'b01 (+1) -> lt=1. The same operands with SIGNED_CMP=0 -> gt=1. With CMP_2B_STATS_EN, cnt_lt increments by 1 per lt result.

Source files
------------

// File: rtl/cmp_2b.sv
// Registered lt/eq/gt magnitude comparator slice with cascade inputs; optional
// result counters under CMP_2B_STATS_EN. Latency 1 clock; no backpressure.
// Accepts a new operand pair every cycle.
module cmp_2b #(
  parameter int WIDTH      = 2,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             casc_eq,
  input  logic             casc_lt,
  input  logic             casc_gt,
  output logic             out_valid,
  output logic             eq,
  output logic             lt,
  output logic             gt
`ifdef CMP_2B_STATS_EN
  ,
  output logic [15:0]      cnt_lt,
  output logic [15:0]      cnt_eq,
  output logic [15:0]      cnt_gt
`endif
);

  logic leq, llt, lgt;
  logic c_eq, c_lt, c_gt;
  logic eq_n, lt_n, gt_n;

  always_comb begin
    leq = (a == b);
    if (SIGNED_CMP) begin
      llt = ($signed(a) < $signed(b));
      lgt = ($signed(a) > $signed(b));
    end else begin
      llt = (a < b);
      lgt = (a > b);
    end
  end

  // Cascade is normalised to one-hot with priority lt > gt > eq; an all-low
  // cascade falls through to the local result so the outputs stay one-hot.
  always_comb begin
    c_lt = casc_lt;
    c_gt = ~casc_lt & casc_gt;
    c_eq = ~casc_lt & ~casc_gt;
    eq_n = c_eq & leq;
    lt_n = c_lt | (c_eq & llt);
    gt_n = c_gt | (c_eq & lgt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      eq        <= 1'b1;
      lt        <= 1'b0;
      gt        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        eq <= eq_n;
        lt <= lt_n;
        gt <= gt_n;
      end
    end
  end

`ifdef CMP_2B_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lt <= 16'd0;
      cnt_eq <= 16'd0;
      cnt_gt <= 16'd0;
    end else if (in_valid) begin
      if (lt_n && (cnt_lt != 16'hFFFF)) cnt_lt <= cnt_lt + 16'd1;
      if (eq_n && (cnt_eq != 16'hFFFF)) cnt_eq <= cnt_eq + 16'd1;
      if (gt_n && (cnt_gt != 16'hFFFF)) cnt_gt <= cnt_gt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_2b.sv
// Directed bench for cmp_2b: vector table, exhaustive 2-bit sweep, reset,
// hold, two-slice chain and signed-compare sequences.
module tb_cmp_2b;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] a, b;
  logic       casc_eq, casc_lt, casc_gt;
  logic       out_valid, eq, lt, gt;
  logic       s_ov, s_eq, s_lt, s_gt;

  logic       ch_vld;
  logic [3:0] ch_a, ch_b;
  logic [1:0] lo_a, lo_b;
  logic       hi_ov, hi_eq, hi_lt, hi_gt;
  logic       lo_ov, lo_eq, lo_lt, lo_gt;

`ifdef CMP_2B_STATS_EN
  logic [15:0] m_cl, m_ce, m_cg, s_cl, s_ce, s_cg;
  logic [15:0] h_cl, h_ce, h_cg, l_cl, l_ce, l_cg;
  logic [15:0] ref_lt, ref_eq, ref_gt;
`endif

  int checks = 0;
  int errors = 0;

  cmp_2b #(.WIDTH(2), .SIGNED_CMP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .casc_eq(casc_eq), .casc_lt(casc_lt), .casc_gt(casc_gt),
    .out_valid(out_valid), .eq(eq), .lt(lt), .gt(gt)
`ifdef CMP_2B_STATS_EN
    , .cnt_lt(m_cl), .cnt_eq(m_ce), .cnt_gt(m_cg)
`endif
  );

  cmp_2b #(.WIDTH(2), .SIGNED_CMP(1'b1)) u_sdut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .casc_eq(casc_eq), .casc_lt(casc_lt), .casc_gt(casc_gt),
    .out_valid(s_ov), .eq(s_eq), .lt(s_lt), .gt(s_gt)
`ifdef CMP_2B_STATS_EN
    , .cnt_lt(s_cl), .cnt_eq(s_ce), .cnt_gt(s_cg)
`endif
  );

  cmp_2b #(.WIDTH(2), .SIGNED_CMP(1'b0)) u_hi (
    .clk(clk), .rst(rst), .in_valid(ch_vld), .a(ch_a[3:2]), .b(ch_b[3:2]),
    .casc_eq(1'b1), .casc_lt(1'b0), .casc_gt(1'b0),
    .out_valid(hi_ov), .eq(hi_eq), .lt(hi_lt), .gt(hi_gt)
`ifdef CMP_2B_STATS_EN
    , .cnt_lt(h_cl), .cnt_eq(h_ce), .cnt_gt(h_cg)
`endif
  );

  cmp_2b #(.WIDTH(2), .SIGNED_CMP(1'b0)) u_lo (
    .clk(clk), .rst(rst), .in_valid(hi_ov), .a(lo_a), .b(lo_b),
    .casc_eq(hi_eq), .casc_lt(hi_lt), .casc_gt(hi_gt),
    .out_valid(lo_ov), .eq(lo_eq), .lt(lo_lt), .gt(lo_gt)
`ifdef CMP_2B_STATS_EN
    , .cnt_lt(l_cl), .cnt_eq(l_ce), .cnt_gt(l_cg)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Low-slice operands trail the high slice by one stage.
  always @(posedge clk) begin
    lo_a <= ch_a[1:0];
    lo_b <= ch_b[1:0];
  end

`ifdef CMP_2B_STATS_EN
  // Reference counters built from the bench's own view of the applied vectors.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_lt <= 16'd0; ref_eq <= 16'd0; ref_gt <= 16'd0;
    end else if (in_valid) begin
      if (casc_lt)                            ref_lt <= ref_lt + 16'd1;
      else if (casc_gt)                       ref_gt <= ref_gt + 16'd1;
      else if (a < b)                         ref_lt <= ref_lt + 16'd1;
      else if (a > b)                         ref_gt <= ref_gt + 16'd1;
      else                                    ref_eq <= ref_eq + 16'd1;
    end
  end
`endif

  typedef struct {
    logic [1:0] va;
    logic [1:0] vb;
    logic       ce;
    logic       cl;
    logic       cg;
    logic [3:0] exp;   // {out_valid, lt, eq, gt}
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b1010, "sa_0_0"};
    vecs[1] = '{2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 4'b1001, "sa_3_0"};
    vecs[2] = '{2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 4'b1100, "sa_0_3"};
    vecs[3] = '{2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1100, "sa_1_2"};
    vecs[4] = '{2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 4'b1001, "casc_gt_ovr"};
    vecs[5] = '{2'd3, 2'd0, 1'b0, 1'b1, 1'b1, 4'b1100, "casc_lt_gt_ill"};
    vecs[6] = '{2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 4'b1001, "casc_gt_eq_ill"};
    vecs[7] = '{2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 4'b1010, "sa_2_2"};

    // Reset held with a live input: outputs pinned to the reset value.
    rst = 1'b1; in_valid = 1'b1; a = 2'd3; b = 2'd0;
    casc_eq = 1'b1; casc_lt = 1'b0; casc_gt = 1'b0;
    ch_vld = 1'b0; ch_a = 4'd0; ch_b = 4'd0;
    #1;
    chk("rst_async", {out_valid, lt, eq, gt}, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_held", {out_valid, lt, eq, gt}, 4'b0010);
    end
    rst = 1'b0;
    tick();
    chk("rst_release_first", {out_valid, lt, eq, gt}, 4'b1001);

    // Table vectors, back-to-back.
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].va; b = vecs[i].vb;
      casc_eq = vecs[i].ce; casc_lt = vecs[i].cl; casc_gt = vecs[i].cg;
      tick();
      chk(vecs[i].name, {out_valid, lt, eq, gt}, vecs[i].exp);
    end

    // Exhaustive unsigned sweep, back-to-back.
    casc_eq = 1'b1; casc_lt = 1'b0; casc_gt = 1'b0;
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        a = 2'(ai); b = 2'(bi);
        tick();
        chk($sformatf("exh_%0d_%0d", ai, bi), {out_valid, lt, eq, gt},
            {1'b1, ai < bi, ai == bi, ai > bi});
        chk("exh_onehot", {3'b000, $onehot({lt, eq, gt})}, 4'b0001);
      end
    end

    // Signed vs unsigned on the same operands: -2 < +1, but 2 > 1.
    a = 2'b10; b = 2'b01;
    tick();
    chk("signed_m2_p1", {s_ov, s_lt, s_eq, s_gt}, 4'b1100);
    chk("unsigned_2_1", {out_valid, lt, eq, gt}, 4'b1001);

    // Hold: in_valid low keeps flags, drops out_valid.
    a = 2'd0; b = 2'd3;
    tick();
    chk("pre_hold", {out_valid, lt, eq, gt}, 4'b1100);
    in_valid = 1'b0; a = 2'd3; b = 2'd0;
    tick();
    chk("hold_1", {out_valid, lt, eq, gt}, 4'b0100);
    tick();
    chk("hold_2", {out_valid, lt, eq, gt}, 4'b0100);

`ifdef CMP_2B_STATS_EN
    chk("cnt_lt_pre", {3'b000, m_cl == ref_lt}, 4'b0001);
    chk("cnt_eq_pre", {3'b000, m_ce == ref_eq}, 4'b0001);
    chk("cnt_gt_pre", {3'b000, m_cg == ref_gt}, 4'b0001);
    in_valid = 1'b1; a = 2'd1; b = 2'd3;
    tick();
    chk("cnt_lt_step", {3'b000, m_cl == ref_lt}, 4'b0001);
    in_valid = 1'b0;
`endif

    // Mid-stream reset discards the in-flight result.
    in_valid = 1'b1; a = 2'd3; b = 2'd0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst", {out_valid, lt, eq, gt}, 4'b0010);
    tick();
    chk("mid_rst_clk", {out_valid, lt, eq, gt}, 4'b0010);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_idle", {out_valid, lt, eq, gt}, 4'b0010);
    in_valid = 1'b1; a = 2'd0; b = 2'd1;
    tick();
    chk("post_rst_first", {out_valid, lt, eq, gt}, 4'b1100);
    in_valid = 1'b0;

`ifdef CMP_2B_STATS_EN
    chk("cnt_lt_after_rst", {3'b000, m_cl == 16'd1}, 4'b0001);
    chk("cnt_gt_after_rst", {3'b000, m_cg == 16'd0}, 4'b0001);
`endif

    // Two-slice 4-bit chain: pairs 0/0, 3/0, 0/3, 7/5.
    begin
      logic [3:0] pa[4];
      logic [3:0] pb[4];
      logic [3:0] pe[4];
      pa[0] = 4'd0; pb[0] = 4'd0; pe[0] = 4'b1010;
      pa[1] = 4'd3; pb[1] = 4'd0; pe[1] = 4'b1001;
      pa[2] = 4'd0; pb[2] = 4'd3; pe[2] = 4'b1100;
      pa[3] = 4'd7; pb[3] = 4'd5; pe[3] = 4'b1001;
      for (int i = 0; i < 5; i++) begin
        if (i < 4) begin
          ch_vld = 1'b1; ch_a = pa[i]; ch_b = pb[i];
        end else begin
          ch_vld = 1'b0;
        end
        tick();
        if (i >= 1)
          chk($sformatf("chain_%0d", i - 1), {lo_ov, lo_lt, lo_eq, lo_gt}, pe[i - 1]);
      end
      tick();
      chk("chain_idle", {3'b000, lo_ov}, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
